// File: rtl/nvme_cpl_tracker_if.sv
// Completion snoop and retire handshake bundle for nvme_cpl_tracker.
// The master side drives completions and retire requests; the tracker is the slave.
interface nvme_cpl_tracker_if #(
    parameter int ACTION_ID_BITS = 4
);
    logic                      cpl_valid;
    logic [127:0]              cpl_entry;
    logic                      ret_req;
    logic [ACTION_ID_BITS-1:0] ret_id;
    logic                      ret_done;
    logic [1:0]                ret_data;

    modport master (
        output cpl_valid,
        output cpl_entry,
        output ret_req,
        output ret_id,
        input  ret_done,
        input  ret_data
    );

    modport slave (
        input  cpl_valid,
        input  cpl_entry,
        input  ret_req,
        input  ret_id,
        output ret_done,
        output ret_data
    );
endinterface

// File: rtl/nvme_cpl_tracker.sv
// Per-action NVMe completion tracker: snoops CQEs into a valid/error slot table and retires
// slots in order per action. Define NVME_TRACK_DUP_CHK_EN to drop duplicate completions (trk_dup).
module nvme_cpl_tracker #(
    parameter int ACTION_ID_BITS = 4,
    parameter int REQ_ID_BITS    = 8,
    parameter int TRACK_DEPTH    = 16,
    parameter int QID_BITS       = 4,
    parameter int ADMIN_QID_A    = 0,
    parameter int ADMIN_QID_B    = 8
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    nvme_cpl_tracker_if.slave             cpl_if,
    output logic                          trk_init,
    output logic [(2**ACTION_ID_BITS)-1:0] trk_ready,
    output logic                          trk_err,
    output logic [127:0]                  trk_err_data,
    input  logic                          trk_err_clear,
    output logic                          trk_range_err
`ifdef NVME_TRACK_DUP_CHK_EN
    ,
    output logic                          trk_dup
`endif
);
    localparam int NUM_ACTIONS = 2**ACTION_ID_BITS;
    localparam int NUM_SLOTS   = NUM_ACTIONS * TRACK_DEPTH;
    localparam int ADDR_BITS   = $clog2(NUM_SLOTS);
    localparam int HEAD_BITS   = $clog2(TRACK_DEPTH);
    localparam int QID_LSB     = 80;
    localparam int ACT_LSB     = QID_LSB + QID_BITS;
    localparam int REQ_LSB     = ACT_LSB + ACTION_ID_BITS;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_CLR  = 3'd2,
        ST_RD   = 3'd3,
        ST_UPD  = 3'd4
    } state_t;

    // Slots are packed action-major with no power-of-2 padding between actions.
    function automatic logic [ADDR_BITS-1:0] slot_addr(
        input logic [ACTION_ID_BITS-1:0] act,
        input logic [REQ_ID_BITS-1:0]    idx
    );
        slot_addr = ADDR_BITS'(act) * ADDR_BITS'(TRACK_DEPTH) + ADDR_BITS'(idx);
    endfunction

    state_t                    state_r;
    logic [ADDR_BITS-1:0]      init_cnt_r;
    logic [ACTION_ID_BITS-1:0] id_r;
    logic [HEAD_BITS-1:0]      head_r [NUM_ACTIONS];
    logic [1:0]                old_data_r;
    logic [1:0]                new_data_r;
    logic                      rd_hit_r;
    logic                      ret_done_r;
    logic [1:0]                ret_data_r;
    logic [1:0]                mem_r [NUM_SLOTS];

    logic [QID_BITS-1:0]       cpl_qid_s;
    logic [ACTION_ID_BITS-1:0] cpl_act_s;
    logic [REQ_ID_BITS-1:0]    cpl_req_s;
    logic [14:0]               cpl_status_s;
    logic                      cpl_acc_s;
    logic                      cpl_admin_s;
    logic                      cpl_range_s;
    logic                      cpl_trk_s;
    logic                      cpl_err_s;
    logic [ADDR_BITS-1:0]      cpl_addr_s;
    logic                      cpl_head_hit_s;
    logic                      cpl_id_hit_s;
    logic [HEAD_BITS-1:0]      head_nxt_s;
    logic [ADDR_BITS-1:0]      cur_addr_s;
    logic                      clr_en_s;
    logic [ADDR_BITS-1:0]      clr_addr_s;
    logic                      wr_en_s;
    logic [ADDR_BITS-1:0]      wr_addr_s;
    logic [1:0]                wr_data_s;
    logic [1:0]                rd_data_s;

    assign cpl_if.ret_done = ret_done_r;
    assign cpl_if.ret_data = ret_data_r;

    // Completion decode; nothing is accepted until the slot sweep has finished.
    always_comb begin
        cpl_qid_s    = cpl_if.cpl_entry[QID_LSB +: QID_BITS];
        cpl_act_s    = cpl_if.cpl_entry[ACT_LSB +: ACTION_ID_BITS];
        cpl_req_s    = cpl_if.cpl_entry[REQ_LSB +: REQ_ID_BITS];
        cpl_status_s = cpl_if.cpl_entry[127:113];
        cpl_acc_s    = cpl_if.cpl_valid & trk_init;
        cpl_admin_s  = (cpl_qid_s == QID_BITS'(ADMIN_QID_A)) ||
                       (cpl_qid_s == QID_BITS'(ADMIN_QID_B));
        cpl_range_s  = cpl_acc_s && !cpl_admin_s &&
                       ({1'b0, cpl_req_s} >= (REQ_ID_BITS+1)'(TRACK_DEPTH));
        cpl_trk_s    = cpl_acc_s && !cpl_admin_s && !cpl_range_s;
        cpl_err_s    = cpl_acc_s && (cpl_status_s != 15'd0);
        cpl_addr_s   = slot_addr(cpl_act_s, cpl_req_s);
        cpl_head_hit_s = cpl_trk_s && (cpl_req_s == REQ_ID_BITS'(head_r[cpl_act_s]));
        cpl_id_hit_s   = cpl_trk_s && (cpl_act_s == id_r) &&
                         (cpl_req_s == REQ_ID_BITS'(head_r[id_r]));
    end

    // Head pointer advance and the slot address the retire FSM is looking at.
    always_comb begin
        if (head_r[id_r] == HEAD_BITS'(TRACK_DEPTH - 1)) begin
            head_nxt_s = {HEAD_BITS{1'b0}};
        end else begin
            head_nxt_s = head_r[id_r] + HEAD_BITS'(1);
        end
        cur_addr_s = slot_addr(id_r, REQ_ID_BITS'(head_r[id_r]));
        clr_en_s   = (state_r == ST_INIT) || (state_r == ST_CLR);
        if (state_r == ST_INIT) begin
            clr_addr_s = init_cnt_r;
        end else begin
            clr_addr_s = cur_addr_s;
        end
    end

`ifdef NVME_TRACK_DUP_CHK_EN
    logic                 pipe_vld_r;
    logic [ADDR_BITS-1:0] pipe_addr_r;
    logic [1:0]           pipe_data_r;
    logic [1:0]           cur_slot_s;
    logic                 cpl_dup_s;

    // Slot contents as they will stand after this edge, including the pending write and any clear.
    always_comb begin
        if (clr_en_s && (clr_addr_s == cpl_addr_s)) begin
            cur_slot_s = 2'b00;
        end else if (pipe_vld_r && (pipe_addr_r == cpl_addr_s)) begin
            cur_slot_s = pipe_data_r;
        end else begin
            cur_slot_s = mem_r[cpl_addr_s];
        end
        cpl_dup_s = cpl_trk_s && cur_slot_s[0];
        wr_en_s   = pipe_vld_r;
        wr_addr_s = pipe_addr_r;
        wr_data_s = pipe_data_r;
    end

    // Read-before-write stage on the completion path.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pipe_vld_r  <= 1'b0;
            pipe_addr_r <= {ADDR_BITS{1'b0}};
            pipe_data_r <= 2'b00;
        end else begin
            pipe_vld_r  <= cpl_trk_s && !cpl_dup_s;
            pipe_addr_r <= cpl_addr_s;
            pipe_data_r <= {(cpl_status_s != 15'd0), 1'b1};
        end
    end

    // Sticky duplicate flag; a new duplicate wins over a same-cycle clear.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            trk_dup <= 1'b0;
        end else if (cpl_dup_s) begin
            trk_dup <= 1'b1;
        end else if (trk_err_clear) begin
            trk_dup <= 1'b0;
        end else begin
            trk_dup <= trk_dup;
        end
    end
`else
    // Completions write straight into the slot table; duplicates overwrite.
    always_comb begin
        wr_en_s   = cpl_trk_s;
        wr_addr_s = cpl_addr_s;
        wr_data_s = {(cpl_status_s != 15'd0), 1'b1};
    end
`endif

    // Retire-side read with forwarding of a same-cycle write to the same slot.
    always_comb begin
        if (wr_en_s && (wr_addr_s == cur_addr_s)) begin
            rd_data_s = wr_data_s;
        end else begin
            rd_data_s = mem_r[cur_addr_s];
        end
    end

    // Slot table; the clear port is listed last so a retire clear beats a colliding write.
    always_ff @(posedge axi_aclk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
        if (clr_en_s) begin
            mem_r[clr_addr_s] <= 2'b00;
        end
    end

    // Init sweep and retire FSM with its registered handshake outputs and head pointers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {ADDR_BITS{1'b0}};
            trk_init   <= 1'b0;
            id_r       <= {ACTION_ID_BITS{1'b0}};
            old_data_r <= 2'b00;
            new_data_r <= 2'b00;
            rd_hit_r   <= 1'b0;
            ret_done_r <= 1'b0;
            ret_data_r <= 2'b00;
            for (int i = 0; i < NUM_ACTIONS; i++) begin
                head_r[i] <= {HEAD_BITS{1'b0}};
            end
        end else begin
            ret_done_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == ADDR_BITS'(NUM_SLOTS - 1)) begin
                        init_cnt_r <= {ADDR_BITS{1'b0}};
                        trk_init   <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        init_cnt_r <= init_cnt_r + ADDR_BITS'(1);
                    end
                end
                ST_IDLE: begin
                    if (cpl_if.ret_req) begin
                        id_r <= cpl_if.ret_id;
                        if (trk_ready[cpl_if.ret_id]) begin
                            state_r <= ST_CLR;
                        end else begin
                            ret_done_r <= 1'b1;
                            ret_data_r <= 2'b00;
                        end
                    end
                end
                ST_CLR: begin
                    old_data_r   <= rd_data_s;
                    head_r[id_r] <= head_nxt_s;
                    state_r      <= ST_RD;
                end
                ST_RD: begin
                    ret_data_r <= old_data_r;
                    new_data_r <= rd_data_s;
                    rd_hit_r   <= cpl_id_hit_s;
                    state_r    <= ST_UPD;
                end
                ST_UPD: begin
                    ret_done_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Per-action head-ready flags; the retire FSM overrides the completion path for its action.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            trk_ready <= {NUM_ACTIONS{1'b0}};
        end else begin
            if (cpl_head_hit_s) begin
                trk_ready[cpl_act_s] <= 1'b1;
            end
            if (state_r == ST_CLR) begin
                trk_ready[id_r] <= 1'b0;
            end else if (state_r == ST_UPD) begin
                trk_ready[id_r] <= new_data_r[0] | rd_hit_r | cpl_id_hit_s;
            end
        end
    end

    // First-error capture; a new error in the clear cycle is captured rather than lost.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            trk_err      <= 1'b0;
            trk_err_data <= 128'd0;
        end else if (cpl_err_s && (!trk_err || trk_err_clear)) begin
            trk_err      <= 1'b1;
            trk_err_data <= cpl_if.cpl_entry;
        end else if (trk_err_clear) begin
            trk_err      <= 1'b0;
            trk_err_data <= 128'd0;
        end else begin
            trk_err      <= trk_err;
            trk_err_data <= trk_err_data;
        end
    end

    // Sticky out-of-range req_id flag.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            trk_range_err <= 1'b0;
        end else if (cpl_range_s) begin
            trk_range_err <= 1'b1;
        end else if (trk_err_clear) begin
            trk_range_err <= 1'b0;
        end else begin
            trk_range_err <= trk_range_err;
        end
    end
endmodule
